// File: rtl/sindoku_btn_pulser_pkg.sv
// -----------------------------------------------------------------------------
// sindoku_btn_pulser_pkg
//   Shared definitions for the sindoku push-button front end:
//   - button index localparams into the packed {C,D,U,L,R} level bus
//   - per-channel debounce FSM state encoding
//   - counter width helper used by every debounce channel
// -----------------------------------------------------------------------------
package sindoku_btn_pulser_pkg;

   localparam int BTN_R = 0;
   localparam int BTN_L = 1;
   localparam int BTN_U = 2;
   localparam int BTN_D = 3;
   localparam int BTN_C = 4;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_PRESS_WAIT = 2'd1,
      S_HELD       = 2'd2,
      S_REL_WAIT   = 2'd3
   } btn_state_t;

   // One counter width covers debounce and repeat timing so the channel
   // can share arithmetic and saturation limits.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sindoku_btn_debounce.sv
// -----------------------------------------------------------------------------
// sindoku_btn_debounce
//   One push-button channel: 2-flop synchroniser, 4-state debounce FSM with a
//   saturating qualification counter, registered one-cycle press pulse and a
//   debounced level. Optional auto-repeat when AUTO_REPEAT_EN is defined and
//   REPEAT_ALLOW is set for this instance.
// Ports
//   Clk    in   system clock
//   Reset  in   asynchronous active-low reset
//   raw    in   raw asynchronous button level, 1 = pressed
//   pulse  out  one-cycle press (and repeat) pulse
//   level  out  debounced button level
// Macro
//   AUTO_REPEAT_EN  enables the hold-to-repeat pulse generator
// -----------------------------------------------------------------------------
module sindoku_btn_debounce
   import sindoku_btn_pulser_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000,
   parameter bit REPEAT_ALLOW    = 1'b1
) (
   input  logic Clk,
   input  logic Reset,
   input  logic raw,
   output logic pulse,
   output logic level
);

   localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync_0;
   logic             sync_1;
   btn_state_t       state;
   btn_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             pulse_nxt;
   logic             level_nxt;
   logic             rpt_fire;

   // --- synchroniser stage ---
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync_0 <= 1'b0;
         sync_1 <= 1'b0;
      end else begin
         sync_0 <= raw;
         sync_1 <= sync_0;
      end
   end

   // --- FSM / output register stage ---
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pulse <= pulse_nxt;
         level <= level_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = 1'b0;
      level_nxt = level;
      case (state)
         S_IDLE: begin
            if (sync_1) begin
               state_nxt = S_PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         S_PRESS_WAIT: begin
            // A single low sample throws away the partial qualification.
            if (!sync_1) begin
               state_nxt = S_IDLE;
            end else if (cnt == DB_LAST) begin
               state_nxt = S_HELD;
               pulse_nxt = 1'b1;
               level_nxt = 1'b1;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_HELD: begin
            if (!sync_1) begin
               state_nxt = S_REL_WAIT;
               cnt_nxt   = '0;
            end else if (rpt_fire) begin
               pulse_nxt = 1'b1;
            end
         end
         S_REL_WAIT: begin
            // Bouncing back high on release returns to HELD silently.
            if (sync_1) begin
               state_nxt = S_HELD;
            end else if (cnt == DB_LAST) begin
               state_nxt = S_IDLE;
               level_nxt = 1'b0;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rpt_cnt;
   logic [CNT_W-1:0] rpt_cnt_nxt;
   logic             rpt_first;
   logic             rpt_first_nxt;

   // --- repeat counter stage ---
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else begin
         rpt_cnt   <= rpt_cnt_nxt;
         rpt_first <= rpt_first_nxt;
      end
   end

   // Counter only runs while the button stays in HELD; any excursion
   // (including release bounce) restarts the long initial delay.
   always_comb begin
      rpt_fire      = 1'b0;
      rpt_cnt_nxt   = '0;
      rpt_first_nxt = 1'b1;
      if (REPEAT_ALLOW && (state == S_HELD) && sync_1) begin
         rpt_first_nxt = rpt_first;
         if (rpt_cnt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
            rpt_fire      = 1'b1;
            rpt_cnt_nxt   = '0;
            rpt_first_nxt = 1'b0;
         end else if (rpt_cnt != CNT_MAX) begin
            rpt_cnt_nxt = rpt_cnt + CNT_ONE;
         end else begin
            rpt_cnt_nxt = rpt_cnt;
         end
      end
   end
`else
   logic unused_repeat_allow;
   assign unused_repeat_allow = REPEAT_ALLOW;
   assign rpt_fire            = 1'b0;
`endif

endmodule

// File: rtl/sindoku_btn_pulser.sv
// -----------------------------------------------------------------------------
// sindoku_btn_pulser
//   Front end for the sindoku core: synchronises and debounces the five raw
//   Nexys-4 push buttons and produces one-clock press pulses plus debounced
//   levels, all in the Clk domain.
// Ports
//   Clk                 in   system clock
//   Reset               in   asynchronous active-low reset
//   BtnR/L/U/D/C        in   raw button levels, 1 = pressed
//   BtnR/L/U/D/C_Pulse  out  one-cycle debounced press pulses
//   Btn_Level[4:0]      out  debounced levels {C,D,U,L,R}
// Macro
//   AUTO_REPEAT_EN  enables hold-to-repeat on R/L/U/D (never on C)
// -----------------------------------------------------------------------------
module sindoku_btn_pulser
   import sindoku_btn_pulser_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       BtnR,
   input  logic       BtnL,
   input  logic       BtnU,
   input  logic       BtnD,
   input  logic       BtnC,
   output logic       BtnR_Pulse,
   output logic       BtnL_Pulse,
   output logic       BtnU_Pulse,
   output logic       BtnD_Pulse,
   output logic       BtnC_Pulse,
   output logic [4:0] Btn_Level
);

   logic [4:0] level;

   sindoku_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ALLOW(1'b1)
   ) u_btn_r (
      .Clk(Clk), .Reset(Reset), .raw(BtnR), .pulse(BtnR_Pulse), .level(level[BTN_R])
   );

   sindoku_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ALLOW(1'b1)
   ) u_btn_l (
      .Clk(Clk), .Reset(Reset), .raw(BtnL), .pulse(BtnL_Pulse), .level(level[BTN_L])
   );

   sindoku_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ALLOW(1'b1)
   ) u_btn_u (
      .Clk(Clk), .Reset(Reset), .raw(BtnU), .pulse(BtnU_Pulse), .level(level[BTN_U])
   );

   sindoku_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ALLOW(1'b1)
   ) u_btn_d (
      .Clk(Clk), .Reset(Reset), .raw(BtnD), .pulse(BtnD_Pulse), .level(level[BTN_D])
   );

   // Centre is the "select" button; repeating it would double-commit moves.
   sindoku_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ALLOW(1'b0)
   ) u_btn_c (
      .Clk(Clk), .Reset(Reset), .raw(BtnC), .pulse(BtnC_Pulse), .level(level[BTN_C])
   );

   assign Btn_Level = level;

endmodule

// File: tb/tb_sindoku_btn_pulser.sv
// -----------------------------------------------------------------------------
// tb_sindoku_btn_pulser
//   Directed bench for sindoku_btn_pulser with short timing parameters.
//   Expected pulses (cycle + {C,D,U,L,R} vector) are queued by the stimulus
//   process; a negedge monitor pops an entry for every cycle with any pulse.
// -----------------------------------------------------------------------------
module tb_sindoku_btn_pulser;

   localparam int DB  = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       BtnR, BtnL, BtnU, BtnD, BtnC;
   logic       BtnR_Pulse, BtnL_Pulse, BtnU_Pulse, BtnD_Pulse, BtnC_Pulse;
   logic [4:0] Btn_Level;

   typedef struct {
      int         cyc;
      logic [4:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   tests  = 0;
   int   failed = 0;

   sindoku_btn_pulser #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .BtnR(BtnR), .BtnL(BtnL), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
      .BtnR_Pulse(BtnR_Pulse), .BtnL_Pulse(BtnL_Pulse), .BtnU_Pulse(BtnU_Pulse),
      .BtnD_Pulse(BtnD_Pulse), .BtnC_Pulse(BtnC_Pulse),
      .Btn_Level(Btn_Level)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         failed++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   function automatic void expect_pulse(input int c, input logic [4:0] v);
      exp_t e;
      e.cyc = c;
      e.vec = v;
      exp_q.push_back(e);
   endfunction

   // Monitor: every cycle carrying a pulse must match the next queued entry.
   always @(negedge Clk) begin
      logic [4:0] pv;
      exp_t       e;
      pv = {BtnC_Pulse, BtnD_Pulse, BtnU_Pulse, BtnL_Pulse, BtnR_Pulse};
      if (pv != 5'b0) begin
         if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_pulse at cycle %0d: got %b, required none", cyc, pv);
         end else begin
            e = exp_q.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_vec", int'(pv), int'(e.vec));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end

   initial begin
      int t;
      Reset = 1'b0;
      BtnR  = 1'b1;
      BtnL  = 1'b0;
      BtnU  = 1'b0;
      BtnD  = 1'b0;
      BtnC  = 1'b0;

      // 1: reset held with BtnR pressed, then requalify
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("reset_outputs",
               int'({BtnC_Pulse, BtnD_Pulse, BtnU_Pulse, BtnL_Pulse, BtnR_Pulse, Btn_Level}), 0);
      end
      Reset = 1'b1;
      t = cyc;
      expect_pulse(t + 7, 5'b00001);
      wait_until(t + 6);
      check("t1_level_before", int'(Btn_Level), 0);
      step(1);
      check("t1_level_after", int'(Btn_Level), 1);
      BtnR = 1'b0;
      step(10);
      check("t1_level_released", int'(Btn_Level), 0);

      // 2: short glitches on BtnU
      BtnU = 1'b1; step(1);
      BtnU = 1'b0; step(1);
      BtnU = 1'b1; step(1);
      BtnU = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (i == 4 || i == 9) check("t2_level_u", int'(Btn_Level[2]), 0);
      end

      // 3: long BtnL hold, release with a 2-cycle blip
      BtnL = 1'b1;
      t = cyc;
      expect_pulse(t + 7, 5'b00010);
`ifdef AUTO_REPEAT_EN
      expect_pulse(t + 27, 5'b00010);
      expect_pulse(t + 35, 5'b00010);
`endif
      step(40);
      check("t3_level_held", int'(Btn_Level[1]), 1);
      BtnL = 1'b0; step(2);
      BtnL = 1'b1; step(2);
      BtnL = 1'b0;
      wait_until(t + 50);
      check("t3_level_before_fall", int'(Btn_Level[1]), 1);
      step(1);
      check("t3_level_after_fall", int'(Btn_Level[1]), 0);
      step(5);

      // 4: simultaneous R and C
      BtnR = 1'b1;
      BtnC = 1'b1;
      t = cyc;
      expect_pulse(t + 7, 5'b10001);
      step(15);
      check("t4_levels", int'(Btn_Level), 5'b10001);
      BtnR = 1'b0;
      BtnC = 1'b0;
      step(10);
      check("t4_levels_released", int'(Btn_Level), 0);

      // 5: long holds on D then C
      BtnD = 1'b1;
      t = cyc;
      expect_pulse(t + 7, 5'b01000);
`ifdef AUTO_REPEAT_EN
      expect_pulse(t + 27, 5'b01000);
      expect_pulse(t + 35, 5'b01000);
      expect_pulse(t + 43, 5'b01000);
      expect_pulse(t + 51, 5'b01000);
`endif
      step(55);
      check("t5_level_d", int'(Btn_Level[3]), 1);
      BtnD = 1'b0;
      step(10);
      BtnC = 1'b1;
      t = cyc;
      expect_pulse(t + 7, 5'b10000);
      step(55);
      check("t5_level_c", int'(Btn_Level[4]), 1);
      BtnC = 1'b0;
      step(10);

      // 6: reset during press qualification on BtnR
      BtnR = 1'b1;
      t = cyc;
      wait_until(t + 5);
      Reset = 1'b0;
      #1;
      check("t6_reset_level", int'(Btn_Level), 0);
      step(2);
      check("t6_reset_pulses",
            int'({BtnC_Pulse, BtnD_Pulse, BtnU_Pulse, BtnL_Pulse, BtnR_Pulse}), 0);
      Reset = 1'b1;
      t = cyc;
      expect_pulse(t + 7, 5'b00001);
      wait_until(t + 6);
      check("t6_level_before", int'(Btn_Level[0]), 0);
      step(1);
      check("t6_level_after", int'(Btn_Level[0]), 1);
      BtnR = 1'b0;
      step(12);

      check("pending_expected_pulses", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
